// File: rtl/motor_pwm_ramp_multi.sv
// Multi-channel H-bridge PWM: one shared period counter, per-channel slew-limited duty
// ramping with a coast dead-time on direction reversal. Targets arrive over valid/ready.
module motor_pwm_ramp_multi #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 10000,
    parameter int RAMP_W     = 8,
    parameter int DEAD_PER   = 2,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  period,
    input  logic [RAMP_W-1:0] ramp_step,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_duty,
    output logic [N_CH-1:0]   pwm_a,
    output logic [N_CH-1:0]   pwm_b,
    output logic [N_CH-1:0]   at_target,
    output logic              period_tick,
    output logic [CNT_W-1:0]  cnt
);

    localparam int DW = (DEAD_PER > 0) ? $clog2(DEAD_PER + 1) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_DECEL, ST_DEAD} ch_state_t;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] period_q;
    logic             period_tick_reg;
    logic             cmd_ready_reg;
    logic             boundary;

    assign boundary    = en && (cnt_reg == period_q - CNT_W'(1));
    assign cnt         = cnt_reg;
    assign period_tick = period_tick_reg;
    assign cmd_ready   = cmd_ready_reg;

    // Move cur toward tgt by at most step, never overshooting; step 0 jumps straight to tgt.
    function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt,
                                                     input logic [RAMP_W-1:0] step);
        logic [CNT_W:0] c, t, s, r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        s = (CNT_W+1)'(step);
        r = t;
        if (step != '0) begin
            if (c < t)
                r = (c + s < t) ? c + s : t;
            else if (c > t + s)
                r = c - s;
        end
        return r[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] ramp_down(input logic [CNT_W-1:0] cur,
                                                   input logic [RAMP_W-1:0] step);
        logic [CNT_W:0] c, s, r;
        c = {1'b0, cur};
        s = (CNT_W+1)'(step);
        r = (step == '0 || c <= s) ? '0 : c - s;
        return r[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg         <= '0;
            period_q        <= CNT_W'(DEF_PERIOD);
            period_tick_reg <= 1'b0;
            cmd_ready_reg   <= 1'b0;
        end else begin
            cmd_ready_reg <= 1'b1;
            if (!en) begin
                cnt_reg         <= '0;
                period_tick_reg <= 1'b0;
            end else begin
                period_tick_reg <= boundary;
                if (boundary) begin
                    cnt_reg  <= '0;
                    period_q <= (period < CNT_W'(2)) ? CNT_W'(2) : period;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             tgt_dir_reg, cur_dir_reg;
        logic [CNT_W-1:0] tgt_duty_reg, cur_duty_reg;
        ch_state_t        state_reg;
        logic [DW-1:0]    dead_cnt_reg;
        logic             pwm_a_reg, pwm_b_reg, at_target_reg;
        logic             wr, on;
        logic [CNT_W-1:0] duty_eff, ramp_val, restart_val, decel_val;

        assign wr          = cmd_valid && cmd_ready_reg && (cmd_ch == CH_W'(gi));
        assign duty_eff    = (cur_duty_reg < period_q) ? cur_duty_reg : period_q;
        assign on          = cnt_reg < duty_eff;
        assign ramp_val    = ramp_toward(cur_duty_reg, tgt_duty_reg, ramp_step);
        assign restart_val = ramp_toward('0, tgt_duty_reg, ramp_step);
        assign decel_val   = ramp_down(cur_duty_reg, ramp_step);

        assign pwm_a[gi]     = pwm_a_reg;
        assign pwm_b[gi]     = pwm_b_reg;
        assign at_target[gi] = at_target_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tgt_dir_reg   <= 1'b1;
                tgt_duty_reg  <= '0;
                cur_dir_reg   <= 1'b1;
                cur_duty_reg  <= '0;
                state_reg     <= ST_RUN;
                dead_cnt_reg  <= '0;
                pwm_a_reg     <= 1'b0;
                pwm_b_reg     <= 1'b0;
                at_target_reg <= 1'b0;
            end else begin
                if (wr) begin
                    tgt_dir_reg  <= cmd_dir;
                    tgt_duty_reg <= cmd_duty;
                end
                at_target_reg <= (state_reg == ST_RUN) && (cur_dir_reg == tgt_dir_reg)
                                 && (cur_duty_reg == tgt_duty_reg);
                if (!en) begin
                    cur_duty_reg <= '0;
                    cur_dir_reg  <= tgt_dir_reg;
                    state_reg    <= ST_RUN;
                    dead_cnt_reg <= '0;
                    pwm_a_reg    <= 1'b0;
                    pwm_b_reg    <= 1'b0;
                end else begin
                    pwm_a_reg <= on && cur_dir_reg && (state_reg != ST_DEAD);
                    pwm_b_reg <= on && !cur_dir_reg && (state_reg != ST_DEAD);
                    if (boundary) begin
                        case (state_reg)
                            ST_RUN: begin
                                if (tgt_dir_reg == cur_dir_reg) begin
                                    cur_duty_reg <= ramp_val;
                                end else if (cur_duty_reg != '0) begin
                                    state_reg <= ST_DECEL;
                                end else if (DEAD_PER == 0) begin
                                    cur_dir_reg <= tgt_dir_reg;
                                end else begin
                                    state_reg    <= ST_DEAD;
                                    dead_cnt_reg <= DW'(DEAD_PER);
                                end
                            end
                            ST_DECEL: begin
                                if (tgt_dir_reg == cur_dir_reg) begin
                                    state_reg <= ST_RUN;
                                end else begin
                                    cur_duty_reg <= decel_val;
                                    if (decel_val == '0) begin
                                        state_reg    <= ST_DEAD;
                                        dead_cnt_reg <= DW'(DEAD_PER);
                                    end
                                end
                            end
                            ST_DEAD: begin
                                // Last dead boundary: flip and start ramping in the new
                                // direction so exactly DEAD_PER periods are coasted.
                                if (dead_cnt_reg <= DW'(1)) begin
                                    cur_dir_reg  <= tgt_dir_reg;
                                    cur_duty_reg <= restart_val;
                                    state_reg    <= ST_RUN;
                                    dead_cnt_reg <= '0;
                                end else begin
                                    dead_cnt_reg <= dead_cnt_reg - DW'(1);
                                end
                            end
                            default: state_reg <= ST_RUN;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_ramp_multi.sv
// Directed bench for motor_pwm_ramp_multi: per-period on-time counts, ramps, reversal
// dead-time, duty saturation, period reload, enable and asynchronous reset behaviour.
module tb_motor_pwm_ramp_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] period;
    logic [7:0]  ramp_step;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_ch;
    logic        cmd_dir;
    logic [15:0] cmd_duty;
    logic [1:0]  pwm_a;
    logic [1:0]  pwm_b;
    logic [1:0]  at_target;
    logic        period_tick;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    int on_a[8][2];
    int on_b[8][2];
    int atg[8][2];
    int overlap;

    always #5 clk = ~clk;

    motor_pwm_ramp_multi #(
        .N_CH(2), .CNT_W(16), .DEF_PERIOD(10), .RAMP_W(8), .DEAD_PER(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .ramp_step(ramp_step),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .pwm_a(pwm_a), .pwm_b(pwm_b),
        .at_target(at_target), .period_tick(period_tick), .cnt(cnt)
    );

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 100);
        checks++;
        if (period_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout period_tick=%b after %0d cycles, need 1", period_tick, n);
        end
    endtask

    task automatic write_cmd(input int ch, input logic dir, input int duty);
        cmd_ch    = 1'(ch);
        cmd_dir   = dir;
        cmd_duty  = 16'(duty);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd ch=%0d dir=%0d duty=%0d", ch, dir, duty);
    endtask

    // Period k's pwm appears one cycle late, so sample from cnt==1 through the next cnt==0.
    task automatic measure_seq(input int n, input int p);
        overlap = 0;
        wait_tick();
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 2; c++) begin
                on_a[k][c] = 0;
                on_b[k][c] = 0;
            end
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                for (int c = 0; c < 2; c++) begin
                    on_a[k][c] += int'(pwm_a[c]);
                    on_b[k][c] += int'(pwm_b[c]);
                    if (j == p / 2) atg[k][c] = int'(at_target[c]);
                end
                if ((pwm_a & pwm_b) != 2'b00) overlap++;
            end
            $display("period %0d: a0=%0d b0=%0d a1=%0d b1=%0d tgt=%0d%0d", k,
                     on_a[k][0], on_b[k][0], on_a[k][1], on_b[k][1], atg[k][1], atg[k][0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_a !== 2'b00 || pwm_b !== 2'b00) begin
            errors++;
            $display("FAIL reset_pwm a=%b b=%b need 00/00", pwm_a, pwm_b);
        end
        checks++;
        if (cnt !== 16'd0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt cnt=%0d tick=%b need 0/0", cnt, period_tick);
        end
        checks++;
        if (cmd_ready !== 1'b0 || at_target !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready ready=%b at_target=%b need 0/00", cmd_ready, at_target);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b need 1", cmd_ready);
        end
        checks++;
        if (at_target !== 2'b11) begin
            errors++;
            $display("FAIL idle_at_target got %b need 11", at_target);
        end
        $display("reset checked");
    endtask

    task automatic test_immediate();
        write_cmd(0, 1'b1, 4);
        en = 1'b1;
        measure_seq(1, 10);
        checks++;
        if (on_a[0][0] !== 4 || on_b[0][0] !== 0) begin
            errors++;
            $display("FAIL imm_ch0 a=%0d b=%0d need 4/0", on_a[0][0], on_b[0][0]);
        end
        checks++;
        if (atg[0][0] !== 1) begin
            errors++;
            $display("FAIL imm_at_target got %0d need 1", atg[0][0]);
        end
        checks++;
        if (on_a[0][1] !== 0 || on_b[0][1] !== 0) begin
            errors++;
            $display("FAIL imm_ch1 a=%0d b=%0d need 0/0", on_a[0][1], on_b[0][1]);
        end
    endtask

    task automatic test_ramp();
        int exp_a[4] = '{2, 4, 6, 7};
        int exp_t[4] = '{0, 0, 0, 1};
        write_cmd(0, 1'b1, 0);
        wait_tick();
        ramp_step = 8'd2;
        write_cmd(0, 1'b1, 7);
        measure_seq(4, 10);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (on_a[k][0] !== exp_a[k] || on_b[k][0] !== 0) begin
                errors++;
                $display("FAIL ramp_on[%0d] a=%0d b=%0d need %0d/0", k, on_a[k][0], on_b[k][0], exp_a[k]);
            end
            checks++;
            if (atg[k][0] !== exp_t[k]) begin
                errors++;
                $display("FAIL ramp_at_target[%0d] got %0d need %0d", k, atg[k][0], exp_t[k]);
            end
        end
    endtask

    task automatic test_reverse();
        int exp_a[6] = '{6, 3, 0, 0, 0, 0};
        int exp_b[6] = '{0, 0, 0, 0, 3, 6};
        int exp_t[6] = '{0, 0, 0, 0, 0, 1};
        ramp_step = 8'd0;
        write_cmd(0, 1'b1, 6);
        wait_tick();
        ramp_step = 8'd3;
        write_cmd(0, 1'b0, 6);
        measure_seq(6, 10);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (on_a[k][0] !== exp_a[k] || on_b[k][0] !== exp_b[k]) begin
                errors++;
                $display("FAIL rev_on[%0d] a=%0d b=%0d need %0d/%0d", k, on_a[k][0], on_b[k][0],
                         exp_a[k], exp_b[k]);
            end
            checks++;
            if (atg[k][0] !== exp_t[k]) begin
                errors++;
                $display("FAIL rev_at_target[%0d] got %0d need %0d", k, atg[k][0], exp_t[k]);
            end
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL rev_overlap got %0d cycles need 0", overlap);
        end
    endtask

    task automatic test_saturation();
        int n;
        ramp_step = 8'd0;
        write_cmd(1, 1'b1, 15);
        measure_seq(2, 10);
        checks++;
        if (on_a[0][1] !== 10 || on_a[1][1] !== 10) begin
            errors++;
            $display("FAIL sat_high a=%0d,%0d need 10,10", on_a[0][1], on_a[1][1]);
        end
        write_cmd(1, 1'b1, 0);
        measure_seq(1, 10);
        checks++;
        if (on_a[0][1] !== 0 || on_b[0][1] !== 0) begin
            errors++;
            $display("FAIL sat_low a=%0d b=%0d need 0/0", on_a[0][1], on_b[0][1]);
        end
        period = 16'd1;
        wait_tick();
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 100);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL period_min spacing=%0d need 2", n);
        end
        $display("period=1 tick spacing %0d", n);
        period = 16'd10;
        wait_tick();
        wait_tick();
    endtask

    task automatic test_period_change();
        int n;
        repeat (3) @(negedge clk);
        checks++;
        if (cnt !== 16'd3) begin
            errors++;
            $display("FAIL pchg_cnt got %0d need 3", cnt);
        end
        period = 16'd20;
        n = 3;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 100);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL pchg_first spacing=%0d need 10", n);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 100);
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL pchg_second spacing=%0d need 20", n);
        end
        $display("period change spacing 10 then %0d", n);
        period = 16'd10;
        wait_tick();
        wait_tick();
    endtask

    task automatic test_disable();
        int exp0[3] = '{3, 6, 8};
        int exp1[3] = '{3, 5, 5};
        en = 1'b0;
        repeat (2) @(negedge clk);
        ramp_step = 8'd0;
        write_cmd(0, 1'b1, 8);
        write_cmd(1, 1'b0, 5);
        repeat (2) @(negedge clk);
        en = 1'b1;
        measure_seq(1, 10);
        checks++;
        if (on_a[0][0] !== 8 || on_b[0][1] !== 5 || on_a[0][1] !== 0) begin
            errors++;
            $display("FAIL dis_run a0=%0d b1=%0d a1=%0d need 8/5/0", on_a[0][0], on_b[0][1], on_a[0][1]);
        end
        wait_tick();
        repeat (4) @(negedge clk);
        checks++;
        if (pwm_a[0] !== 1'b1 || pwm_b[1] !== 1'b1) begin
            errors++;
            $display("FAIL dis_pre a0=%b b1=%b need 1/1", pwm_a[0], pwm_b[1]);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt !== 16'd0 || pwm_a !== 2'b00 || pwm_b !== 2'b00 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL dis_off cnt=%0d a=%b b=%b tick=%b need 0/00/00/0", cnt, pwm_a, pwm_b, period_tick);
        end
        ramp_step = 8'd3;
        en = 1'b1;
        measure_seq(3, 10);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (on_a[k][0] !== exp0[k] || on_b[k][1] !== exp1[k]) begin
                errors++;
                $display("FAIL reen_ramp[%0d] a0=%0d b1=%0d need %0d/%0d", k, on_a[k][0], on_b[k][1],
                         exp0[k], exp1[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_a[0] !== 1'b1 || pwm_b[1] !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre a0=%b b1=%b need 1/1", pwm_a[0], pwm_b[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pwm_a !== 2'b00 || pwm_b !== 2'b00 || cnt !== 16'd0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_now a=%b b=%b cnt=%0d ready=%b need 00/00/0/0", pwm_a, pwm_b, cnt, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_ready got %b need 1", cmd_ready);
        end
        write_cmd(0, 1'b1, 8);
        measure_seq(3, 10);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (on_a[k][0] !== 3 * k + 3 - ((k == 2) ? 1 : 0) || on_b[k][1] !== 0) begin
                errors++;
                $display("FAIL arst_ramp[%0d] a0=%0d b1=%0d need %0d/0", k, on_a[k][0], on_b[k][1],
                         3 * k + 3 - ((k == 2) ? 1 : 0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        period    = 16'd10;
        ramp_step = 8'd0;
        cmd_valid = 1'b0;
        cmd_ch    = 1'b0;
        cmd_dir   = 1'b1;
        cmd_duty  = 16'd0;
        test_reset();
        test_immediate();
        test_ramp();
        test_reverse();
        test_saturation();
        test_period_change();
        test_disable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
